// File: rtl/wb_stage_pipe_if.sv
// MEM_WB -> writeback stage bus and the writeback stage -> ID register-file write port.
// The master side drives the retiring instruction; the slave side is the stage itself.
interface wb_stage_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     alu_out;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     pc_plus4;
    logic [REG_ADDR_W-1:0] reg_dest_in;
    logic                  wb_sel;
    logic                  reg_wr_in;
    logic                  call;
    logic [1:0]            ld_size;
    logic                  ld_signed;
    logic [DATA_W-1:0]     reg_wr_data;
    logic [REG_ADDR_W-1:0] reg_dest_out;
    logic                  reg_wr_out;
    logic                  stall;
    logic                  misalign_err;
    logic [CNT_W-1:0]      retired_cnt;

    modport master (
        output in_valid, alu_out, mem_rdata, mem_rvalid, pc_plus4, reg_dest_in,
               wb_sel, reg_wr_in, call, ld_size, ld_signed,
        input  in_ready, reg_wr_data, reg_dest_out, reg_wr_out, stall,
               misalign_err, retired_cnt
    );

    modport slave (
        input  in_valid, alu_out, mem_rdata, mem_rvalid, pc_plus4, reg_dest_in,
               wb_sel, reg_wr_in, call, ld_size, ld_signed,
        output in_ready, reg_wr_data, reg_dest_out, reg_wr_out, stall,
               misalign_err, retired_cnt
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: selects ALU / aligned load / link data, waits on late
// memory responses while stalling upstream, and counts retired register writes.
module wb_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int LINK_REG   = 15,
    parameter int CNT_W      = 16
) (
    input logic          clk,
    input logic          rst,
    wb_stage_pipe_if.slave bus
);
    typedef enum logic {IDLE, WAIT_MEM} state_e;

    state_e                state_q, state_d;
    logic [1:0]            cap_lane_q, cap_lane_d;
    logic [1:0]            cap_size_q, cap_size_d;
    logic                  cap_signed_q, cap_signed_d;
    logic                  cap_wr_q, cap_wr_d;
    logic [REG_ADDR_W-1:0] cap_dest_q, cap_dest_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  accept, use_cap, ld_fire, ld_misal, ld_sgn, ld_wr;
    logic [1:0]            ld_lane, ld_size;
    logic [REG_ADDR_W-1:0] ld_dest;

    // Little-endian lane select with optional sign extension for byte/half loads.
    function automatic logic [DATA_W-1:0] load_align(input logic [DATA_W-1:0] rdata,
                                                     input logic [1:0] lane,
                                                     input logic [1:0] size,
                                                     input logic sgn);
        logic [DATA_W-1:0] sh;
        logic [7:0]        b;
        logic [15:0]       h;
        sh = rdata >> {lane, 3'b000};
        b  = sh[7:0];
        h  = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   load_align = {{(DATA_W-8){sgn & b[7]}}, b};
            2'b01:   load_align = {{(DATA_W-16){sgn & h[15]}}, h};
            default: load_align = rdata;
        endcase
    endfunction

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.stall        = (state_q == WAIT_MEM);
    assign bus.reg_wr_data  = wr_data_q;
    assign bus.reg_dest_out = dest_q;
    assign bus.reg_wr_out   = wr_q;
    assign bus.misalign_err = err_q;
    assign bus.retired_cnt  = cnt_q;

    assign accept = bus.in_valid & (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        cap_lane_d   = cap_lane_q;
        cap_size_d   = cap_size_q;
        cap_signed_d = cap_signed_q;
        cap_wr_d     = cap_wr_q;
        cap_dest_d   = cap_dest_q;
        wr_data_d    = wr_data_q;
        dest_d       = dest_q;
        wr_d         = 1'b0;
        err_d        = 1'b0;
        ld_fire      = 1'b0;

        // A waiting load completes from its captured fields, never from the live bus.
        use_cap  = (state_q == WAIT_MEM);
        ld_lane  = use_cap ? cap_lane_q   : bus.alu_out[1:0];
        ld_size  = use_cap ? cap_size_q   : bus.ld_size;
        ld_sgn   = use_cap ? cap_signed_q : bus.ld_signed;
        ld_wr    = use_cap ? cap_wr_q     : bus.reg_wr_in;
        ld_dest  = use_cap ? cap_dest_q   : bus.reg_dest_in;
        ld_misal = ((ld_size == 2'b01) && ld_lane[0]) || (ld_size[1] && (ld_lane != 2'b00));

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.call) begin
                        wr_data_d = bus.pc_plus4;
                        dest_d    = LINK_REG[REG_ADDR_W-1:0];
                        wr_d      = bus.reg_wr_in;
                    end else if (!bus.wb_sel) begin
                        wr_data_d = bus.alu_out;
                        dest_d    = bus.reg_dest_in;
                        wr_d      = bus.reg_wr_in;
                    end else if (bus.mem_rvalid) begin
                        ld_fire = 1'b1;
                    end else begin
                        cap_lane_d   = bus.alu_out[1:0];
                        cap_size_d   = bus.ld_size;
                        cap_signed_d = bus.ld_signed;
                        cap_wr_d     = bus.reg_wr_in;
                        cap_dest_d   = bus.reg_dest_in;
                        state_d      = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    ld_fire = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase

        if (ld_fire) begin
            if (ld_misal) begin
                err_d = 1'b1;
            end else begin
                wr_data_d = load_align(bus.mem_rdata, ld_lane, ld_size, ld_sgn);
                dest_d    = ld_dest;
                wr_d      = ld_wr;
            end
        end

        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, wr_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cap_lane_q   <= '0;
            cap_size_q   <= '0;
            cap_signed_q <= 1'b0;
            cap_wr_q     <= 1'b0;
            cap_dest_q   <= '0;
            wr_data_q    <= '0;
            dest_q       <= '0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            cap_lane_q   <= cap_lane_d;
            cap_size_q   <= cap_size_d;
            cap_signed_q <= cap_signed_d;
            cap_wr_q     <= cap_wr_d;
            cap_dest_q   <= cap_dest_d;
            wr_data_q    <= wr_data_d;
            dest_q       <= dest_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: one task per scenario, plus a narrow-counter
// instance to exercise retired-count wraparound.
module tb_wb_stage_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(16)) b ();
    wb_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(4))  b4 ();

    wb_stage_pipe #(.DATA_W(32), .REG_ADDR_W(4), .LINK_REG(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(b.slave));
    wb_stage_pipe #(.DATA_W(32), .REG_ADDR_W(4), .LINK_REG(15), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(b4.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b.in_valid = 0; b.alu_out = 0; b.mem_rdata = 0; b.mem_rvalid = 0; b.pc_plus4 = 0;
        b.reg_dest_in = 0; b.wb_sel = 0; b.reg_wr_in = 0; b.call = 0; b.ld_size = 0; b.ld_signed = 0;
    endtask

    task automatic load_op(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                           input logic [31:0] rdata, input logic rv, input logic [3:0] dest);
        b.in_valid = 1; b.wb_sel = 1; b.call = 0; b.reg_wr_in = 1; b.alu_out = addr;
        b.ld_size = size; b.ld_signed = sgn; b.mem_rdata = rdata; b.mem_rvalid = rv; b.reg_dest_in = dest;
    endtask

    task automatic test_reset();
        idle_inputs();
        b4.in_valid = 0; b4.alu_out = 0; b4.mem_rdata = 0; b4.mem_rvalid = 0; b4.pc_plus4 = 0;
        b4.reg_dest_in = 0; b4.wb_sel = 0; b4.reg_wr_in = 0; b4.call = 0; b4.ld_size = 0; b4.ld_signed = 0;
        rst = 1; step(); step(); rst = 0;
        checks++; if (b.reg_wr_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%0h exp=0", b.reg_wr_data); end
        checks++; if (b.reg_dest_out !== 4'h0) begin failures++; $display("FAIL rst_dest got=%0h exp=0", b.reg_dest_out); end
        checks++; if ({b.reg_wr_out, b.misalign_err, b.stall, b.in_ready} !== 4'b0001) begin failures++; $display("FAIL rst_flags got=%b exp=0001", {b.reg_wr_out, b.misalign_err, b.stall, b.in_ready}); end
        checks++; if (b.retired_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", b.retired_cnt); end
    endtask

    task automatic test_alu();
        b.in_valid = 1; b.wb_sel = 0; b.call = 0; b.reg_wr_in = 1; b.alu_out = 32'h1234_5678; b.reg_dest_in = 4'd3;
        step();
        idle_inputs();
        checks++; if (b.reg_wr_out !== 1'b1) begin failures++; $display("FAIL alu_wr got=%b exp=1", b.reg_wr_out); end
        checks++; if (b.reg_wr_data !== 32'h1234_5678) begin failures++; $display("FAIL alu_data got=%0h exp=12345678", b.reg_wr_data); end
        checks++; if (b.reg_dest_out !== 4'd3) begin failures++; $display("FAIL alu_dest got=%0d exp=3", b.reg_dest_out); end
        checks++; if (b.retired_cnt !== 16'd1) begin failures++; $display("FAIL alu_cnt got=%0d exp=1", b.retired_cnt); end
        step();
        checks++; if (b.reg_wr_out !== 1'b0) begin failures++; $display("FAIL alu_pulse got=%b exp=0", b.reg_wr_out); end
        checks++; if (b.reg_wr_data !== 32'h1234_5678) begin failures++; $display("FAIL alu_hold got=%0h exp=12345678", b.reg_wr_data); end
    endtask

    task automatic test_call();
        b.in_valid = 1; b.wb_sel = 1; b.call = 1; b.reg_wr_in = 1; b.mem_rvalid = 0;
        b.pc_plus4 = 32'h100; b.reg_dest_in = 4'd2; b.alu_out = 32'h3;
        step();
        idle_inputs();
        checks++; if (b.stall !== 1'b0) begin failures++; $display("FAIL call_stall got=%b exp=0", b.stall); end
        checks++; if (b.reg_wr_data !== 32'h100) begin failures++; $display("FAIL call_data got=%0h exp=100", b.reg_wr_data); end
        checks++; if (b.reg_dest_out !== 4'd15) begin failures++; $display("FAIL call_dest got=%0d exp=15", b.reg_dest_out); end
        checks++; if (b.retired_cnt !== 16'd2) begin failures++; $display("FAIL call_cnt got=%0d exp=2", b.retired_cnt); end
    endtask

    task automatic test_load_wait();
        load_op(32'h0000_0001, 2'b00, 1'b1, 32'h0000_8000, 1'b0, 4'd5);
        for (int i = 0; i < 3; i++) begin
            step();
            // live fields change while waiting; completion must use the captured ones
            b.in_valid = 0; b.alu_out = 32'h2; b.ld_size = 2'b10; b.ld_signed = 0; b.reg_dest_in = 4'd9;
            checks++; if ({b.stall, b.in_ready} !== 2'b10) begin failures++; $display("FAIL wait_stall%0d got=%b exp=10", i, {b.stall, b.in_ready}); end
        end
        b.mem_rvalid = 1;
        step();
        idle_inputs();
        checks++; if (b.reg_wr_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL wait_data got=%0h exp=ffffff80", b.reg_wr_data); end
        checks++; if ({b.reg_wr_out, b.reg_dest_out} !== {1'b1, 4'd5}) begin failures++; $display("FAIL wait_wr got=%0h exp=15", {b.reg_wr_out, b.reg_dest_out}); end
        checks++; if (b.stall !== 1'b0) begin failures++; $display("FAIL wait_done got=%b exp=0", b.stall); end
    endtask

    task automatic test_load_align();
        load_op(32'h0000_0002, 2'b01, 1'b0, 32'hBEEF_0000, 1'b1, 4'd6);
        step();
        checks++; if (b.reg_wr_data !== 32'h0000_BEEF) begin failures++; $display("FAIL half_l2 got=%0h exp=beef", b.reg_wr_data); end
        checks++; if (b.retired_cnt !== 16'd4) begin failures++; $display("FAIL half_cnt got=%0d exp=4", b.retired_cnt); end
        load_op(32'h0000_0003, 2'b00, 1'b0, 32'hA500_0000, 1'b1, 4'd6);
        step();
        checks++; if (b.reg_wr_data !== 32'h0000_00A5) begin failures++; $display("FAIL byte_l3 got=%0h exp=a5", b.reg_wr_data); end
        load_op(32'h0000_0000, 2'b01, 1'b1, 32'h1234_8001, 1'b1, 4'd6);
        step();
        idle_inputs();
        checks++; if (b.reg_wr_data !== 32'hFFFF_8001) begin failures++; $display("FAIL half_s0 got=%0h exp=ffff8001", b.reg_wr_data); end
        checks++; if (b.retired_cnt !== 16'd6) begin failures++; $display("FAIL align_cnt got=%0d exp=6", b.retired_cnt); end
    endtask

    task automatic test_misalign();
        load_op(32'h0000_0002, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b1, 4'd7);
        step();
        idle_inputs();
        checks++; if ({b.misalign_err, b.reg_wr_out} !== 2'b10) begin failures++; $display("FAIL mis_flags got=%b exp=10", {b.misalign_err, b.reg_wr_out}); end
        checks++; if ({b.reg_wr_data, b.reg_dest_out} !== {32'hFFFF_8001, 4'd6}) begin failures++; $display("FAIL mis_hold got=%0h exp=ffff80016", {b.reg_wr_data, b.reg_dest_out}); end
        checks++; if (b.retired_cnt !== 16'd6) begin failures++; $display("FAIL mis_cnt got=%0d exp=6", b.retired_cnt); end
        step();
        checks++; if (b.misalign_err !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b exp=0", b.misalign_err); end
        // misaligned half through the waiting path
        load_op(32'h0000_0001, 2'b01, 1'b0, 32'h0, 1'b0, 4'd8);
        step();
        idle_inputs(); b.mem_rvalid = 1;
        step();
        b.mem_rvalid = 0;
        checks++; if ({b.misalign_err, b.reg_wr_out, b.in_ready} !== 3'b101) begin failures++; $display("FAIL mis_wait got=%b exp=101", {b.misalign_err, b.reg_wr_out, b.in_ready}); end
    endtask

    task automatic test_rst_wait();
        load_op(32'h0, 2'b10, 1'b0, 32'h5555_5555, 1'b0, 4'd4);
        step();
        idle_inputs();
        checks++; if (b.stall !== 1'b1) begin failures++; $display("FAIL rw_stall got=%b exp=1", b.stall); end
        rst = 1; b.mem_rvalid = 1; b.mem_rdata = 32'h5555_5555;
        step();
        rst = 0; b.mem_rvalid = 0;
        checks++; if ({b.reg_wr_out, b.misalign_err, b.stall, b.in_ready} !== 4'b0001) begin failures++; $display("FAIL rw_flags got=%b exp=0001", {b.reg_wr_out, b.misalign_err, b.stall, b.in_ready}); end
        checks++; if ({b.reg_wr_data, b.reg_dest_out, b.retired_cnt} !== 52'h0) begin failures++; $display("FAIL rw_zero got=%0h exp=0", {b.reg_wr_data, b.reg_dest_out, b.retired_cnt}); end
        step();
        checks++; if (b.reg_wr_out !== 1'b0) begin failures++; $display("FAIL rw_nowr got=%b exp=0", b.reg_wr_out); end
    endtask

    task automatic test_back_to_back();
        load_op(32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 4'd8);
        step();
        b.wb_sel = 0; b.alu_out = 32'h77; b.reg_dest_in = 4'd9; b.mem_rvalid = 1; b.mem_rdata = 32'hCAFE_F00D;
        step();
        b.mem_rvalid = 0;
        checks++; if ({b.reg_wr_data, b.reg_dest_out} !== {32'hCAFE_F00D, 4'd8}) begin failures++; $display("FAIL b2b_ld got=%0h exp=cafef00d8", {b.reg_wr_data, b.reg_dest_out}); end
        checks++; if (b.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_rdy got=%b exp=1", b.in_ready); end
        step();
        idle_inputs();
        checks++; if ({b.reg_wr_out, b.reg_wr_data, b.reg_dest_out} !== {1'b1, 32'h77, 4'd9}) begin failures++; $display("FAIL b2b_alu got=%0h exp=1000000779", {b.reg_wr_out, b.reg_wr_data, b.reg_dest_out}); end
        checks++; if (b.retired_cnt !== 16'd2) begin failures++; $display("FAIL b2b_cnt got=%0d exp=2", b.retired_cnt); end
    endtask

    task automatic test_wrap();
        b4.in_valid = 1; b4.wb_sel = 0; b4.call = 0; b4.reg_wr_in = 1; b4.reg_dest_in = 4'd1;
        for (int i = 0; i < 17; i++) begin
            b4.alu_out = i;
            step();
            if (i == 15) begin
                checks++; if (b4.retired_cnt !== 4'd0) begin failures++; $display("FAIL wrap16 got=%0d exp=0", b4.retired_cnt); end
            end
        end
        b4.in_valid = 0;
        checks++; if (b4.retired_cnt !== 4'd1) begin failures++; $display("FAIL wrap17 got=%0d exp=1", b4.retired_cnt); end
        step();
        checks++; if (b4.retired_cnt !== 4'd1) begin failures++; $display("FAIL wrap_hold got=%0d exp=1", b4.retired_cnt); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_call();
        test_load_wait();
        test_load_align();
        test_misalign();
        test_rst_wait();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
